// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, HI/LO selects and default latencies shared by the MDU and its issue controller.
// Rev 1.0
`default_nettype none

package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_SWAP  = 4'b1000;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_LO   = 2'b01;
  localparam logic [1:0] RD_HI   = 2'b10;

  localparam int MULT_TIME_DEF = 5;
  localparam int DIV_TIME_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_move_op(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO) || (op == OP_SWAP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_issue_ctrl_sat_counter.sv
// sat_counter: increment-enabled counter that sticks at all-ones instead of wrapping.
// Rev 1.0
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage MDU issue decode, shadow busy tracking, D-stage stall and busy cross-check.
// Rev 1.0
`default_nettype none

module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_TIME = MULT_TIME_DEF,
  parameter int DIV_TIME  = DIV_TIME_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_mdu_class,
  input  logic             e_valid,
  input  logic [3:0]       e_mdu_op,
  input  logic [1:0]       e_read_hilo,
  input  logic             mdu_busy,
  output logic             mdu_start,
  output logic [3:0]       mdu_op,
  output logic [3:0]       mdu_time,
  output logic [1:0]       mdu_read_hilo,
  output logic             stall_d,
  output logic             busy_mismatch,
  output logic [CNT_W-1:0] stat_stalls,
  output logic [CNT_W-1:0] stat_issues
);

  logic [3:0] r_cnt;
  mdu_state_e r_state;
  mdu_state_e w_state_nxt;
  logic       r_mismatch;
  logic       w_move;
  logic       w_model_busy;

  // Bubbles and the reset cycle present OP_NONE so HI/LO can never move spuriously.
  always_comb begin
    w_move        = e_valid && is_move_op(e_mdu_op);
    mdu_start     = e_valid && is_arith_op(e_mdu_op) && !reset;
    mdu_op        = (e_valid && !reset) ? e_mdu_op : OP_NONE;
    mdu_read_hilo = (e_valid && !reset) ? e_read_hilo : RD_NONE;
    mdu_time      = 4'd0;
    case (mdu_op)
      OP_MULT, OP_MULTU: mdu_time = 4'(MULT_TIME);
      OP_DIV, OP_DIVU:   mdu_time = 4'(DIV_TIME);
      default:           mdu_time = 4'd0;
    endcase
    w_model_busy = mdu_start || (r_cnt != 4'd0);
    stall_d      = !reset && d_mdu_class && (w_model_busy || mdu_busy);
  end

  // A new start always wins over the countdown, even if one is still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (mdu_start) begin
      r_cnt <= mdu_time;
    end else if (w_move) begin
      r_cnt <= 4'd0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (mdu_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (mdu_start) begin
          w_state_nxt = ST_RUN;
        end else if (w_move || (r_cnt <= 4'd1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mismatch <= 1'b0;
    end else if (w_model_busy != mdu_busy) begin
      r_mismatch <= 1'b1;
    end
  end

  assign busy_mismatch = r_mismatch;

  sat_counter #(.W(CNT_W)) u_stat_stalls (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (stall_d),
    .o_count (stat_stalls)
  );

  sat_counter #(.W(CNT_W)) u_stat_issues (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (mdu_start),
    .o_count (stat_issues)
  );

endmodule

`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: scoreboard bench for mdu_issue_ctrl with a behavioural MDU busy source.
// Rev 1.0
`default_nettype none

module tb_mdu_issue_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          d_mdu_class = 1'b0;
  logic          e_valid = 1'b0;
  logic [3:0]    e_mdu_op = 4'd0;
  logic [1:0]    e_read_hilo = 2'd0;
  logic          mdu_busy = 1'b0;
  logic          mdu_start;
  logic [3:0]    mdu_op;
  logic [3:0]    mdu_time;
  logic [1:0]    mdu_read_hilo;
  logic          stall_d;
  logic          busy_mismatch;
  logic [CW-1:0] stat_stalls;
  logic [CW-1:0] stat_issues;

  mdu_issue_ctrl #(.MULT_TIME(5), .DIV_TIME(10), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .d_mdu_class   (d_mdu_class),
    .e_valid       (e_valid),
    .e_mdu_op      (e_mdu_op),
    .e_read_hilo   (e_read_hilo),
    .mdu_busy      (mdu_busy),
    .mdu_start     (mdu_start),
    .mdu_op        (mdu_op),
    .mdu_time      (mdu_time),
    .mdu_read_hilo (mdu_read_hilo),
    .stall_d       (stall_d),
    .busy_mismatch (busy_mismatch),
    .stat_stalls   (stat_stalls),
    .stat_issues   (stat_issues)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          start;
    logic [3:0]    op;
    logic [3:0]    tm;
    logic [1:0]    rh;
    logic          stall;
    logic          mm;
    logic [CW-1:0] ss;
    logic [CW-1:0] si;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: the last cycle the operation keeps the MDU busy.
  int            cyc      = 0;
  int            busy_end = -1;
  logic          m_mm     = 1'b0;
  logic [CW-1:0] m_ss     = '0;
  logic [CW-1:0] m_si     = '0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit d, input bit v, input logic [3:0] op, input logic [1:0] rh,
                      input bit f0, input bit rst);
    exp_t e;
    exp_t o;
    bit   st;
    bit   mv;
    bit   busy;
    bit   mb;
    @(posedge clk);
    #1;
    st   = !rst && v && (op inside {4'd1, 4'd2, 4'd3, 4'd4});
    mv   = v && (op inside {4'd5, 4'd6, 4'd8});
    busy = st || (cyc <= busy_end);
    mb   = f0 ? 1'b0 : busy;
    reset = rst; d_mdu_class = d; e_valid = v; e_mdu_op = op; e_read_hilo = rh; mdu_busy = mb;
    e.start = st;
    e.op    = (!rst && v) ? op : 4'd0;
    e.tm    = (e.op == 4'd1 || e.op == 4'd2) ? 4'd5 : (e.op == 4'd3 || e.op == 4'd4) ? 4'd10 : 4'd0;
    e.rh    = (!rst && v) ? rh : 2'd0;
    e.stall = !rst && d && (busy || mb);
    e.mm    = m_mm;
    e.ss    = m_ss;
    e.si    = m_si;
    q_exp.push_back(e);
    if (rst) begin
      busy_end = cyc; m_mm = 1'b0; m_ss = '0; m_si = '0;
    end else begin
      if (st) busy_end = cyc + int'(e.tm);
      else if (mv) busy_end = cyc;
      if (busy != mb) m_mm = 1'b1;
      if (e.stall && m_ss != {CW{1'b1}}) m_ss = m_ss + 1'b1;
      if (st && m_si != {CW{1'b1}}) m_si = m_si + 1'b1;
    end
    @(negedge clk);
    o = q_exp.pop_front();
    chk("mdu_start", mdu_start, o.start);
    chk("mdu_op", mdu_op, o.op);
    chk("mdu_time", mdu_time, o.tm);
    chk("mdu_read_hilo", mdu_read_hilo, o.rh);
    chk("stall_d", stall_d, o.stall);
    chk("busy_mismatch", busy_mismatch, o.mm);
    chk("stat_stalls", stat_stalls, o.ss);
    chk("stat_issues", stat_issues, o.si);
    cyc++;
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) step(d, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
    step(0, 0, 4'd0, 2'd0, 0, 1);
    step(1, 1, 4'd1, 2'd1, 0, 1);
    idle(2, 1'b1);

    // mult with an mflo waiting in D: stall for the start cycle plus five.
    step(1, 1, 4'd1, 2'd0, 0, 0);
    idle(7, 1'b1);

    // divu then mfhi held in D: eleven stalls, one issue since reset.
    step(0, 0, 4'd0, 2'd0, 0, 1);
    step(1, 1, 4'd4, 2'd0, 0, 0);
    idle(12, 1'b1);

    // mthi mid-run collapses busy immediately; bubble carrying mthi does nothing.
    step(0, 1, 4'd2, 2'd0, 0, 0);
    idle(1, 1'b1);
    step(1, 0, 4'd5, 2'd2, 0, 0);
    step(1, 1, 4'd5, 2'd0, 0, 0);
    idle(3, 1'b1);
    step(1, 1, 4'd0, 2'd2, 0, 0);
    step(1, 1, 4'd0, 2'd1, 0, 0);

    // Reset three cycles into a div.
    step(1, 1, 4'd3, 2'd0, 0, 0);
    idle(2, 1'b1);
    step(1, 0, 4'd0, 2'd0, 0, 1);
    idle(3, 1'b1);

    // Faulty MDU reports idle during a mult: sticky mismatch until reset.
    step(1, 1, 4'd1, 2'd0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 4'd0, 2'd0, 1, 0);
    idle(5, 1'b1);
    step(0, 0, 4'd0, 2'd0, 0, 1);
    idle(2, 1'b0);

    // Back-to-back start reloads the countdown.
    step(1, 1, 4'd1, 2'd0, 0, 0);
    idle(2, 1'b1);
    step(1, 1, 4'd3, 2'd0, 0, 0);
    idle(12, 1'b1);

    // Continuous issue with D held saturates both counters.
    for (int i = 0; i < 20; i++) step(1, 1, 4'd2, 2'd0, 0, 0);
    idle(7, 1'b1);
    step(0, 0, 4'd0, 2'd0, 0, 1);

    for (int i = 0; i < 80; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ops[$urandom_range(0, 10)], 2'($urandom_range(0, 3)), 1'b0, ($urandom_range(0, 30) == 0));
    end

    chk("sb_empty", q_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
E-stage issue and hazard controller that sits directly upstream of the multiply/divide unit (MDU) in the 5-stage MIPS pipeline.
- Decodes the E-stage MDU-class instruction into the MDU's start, op, latency and HI/LO-read controls.
- Tracks the outstanding operation with a shadow countdown and stalls the D stage when an MDU-class instruction would collide with an in-flight operation.
- Cross-checks the MDU's busy output against its own model and keeps stall/issue statistics for verification.

Parameters:
- MULT_TIME, 5, latency (cycles after the start cycle) driven on time for mult/multu.
- DIV_TIME, 10, latency driven on time for div/divu.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- d_mdu_class  in  1  D-stage instruction is MDU-class (mult, multu, div, divu, mfhi, mflo, mthi, mtlo, swap).
- e_valid  in  1  E-stage holds a real (non-bubble) instruction.
- e_mdu_op  in  4  E-stage op code: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 1000 swap; all other codes = none.
- e_read_hilo  in  2  E-stage HI/LO read select: 01 LO, 10 HI, else none.
- mdu_busy  in  1  busy output fed back from the MDU.
- mdu_start  out  1  start pulse to the MDU.
- mdu_op  out  4  op code to the MDU.
- mdu_time  out  4  latency to the MDU.
- mdu_read_hilo  out  2  HI/LO read select to the MDU.
- stall_d  out  1  freeze F/D and insert a bubble into E.
- busy_mismatch  out  1  sticky flag: model disagrees with mdu_busy.
- stat_stalls  out  CNT_W  count of stall cycles.
- stat_issues  out  CNT_W  count of start pulses.

Behaviour:
- Reset values: cnt=0, state=IDLE, busy_mismatch=0, both statistics counters=0. All outputs are 0 during the reset cycle; mdu_start is forced 0 while reset is high.
- is_arith = e_valid and e_mdu_op in {0001,0010,0011,0100}.
- Start and op decode:
  - mdu_start = is_arith and not reset. Combinational from the E inputs.
  - mdu_op = e_mdu_op when e_valid, else 0000. A bubble must never move HI/LO.
  - mdu_time = MULT_TIME for ops 0001/0010, DIV_TIME for ops 0011/0100, else 0.
  - mdu_read_hilo = e_read_hilo when e_valid, else 00.
- Shadow counter cnt (4 bits):
  - On mdu_start: cnt <= mdu_time.
  - Otherwise, if cnt != 0: cnt <= cnt - 1.
  - cnt never wraps below 0.
  - mthi/mtlo/swap (0101/0110/1000) force cnt <= 0, matching the MDU's immediate-move semantics.
- State machine:
  - IDLE -> RUN on mdu_start.
  - RUN -> IDLE when cnt == 1 and no new start.
  - RUN -> RUN on mdu_start, which reloads cnt.
  - RUN -> IDLE immediately on a move op.
- model_busy = mdu_start or (cnt != 0).
  - Example: a mult issued at cycle t is busy for cycles t..t+5, 6 cycles total.
- stall_d = d_mdu_class and (model_busy or mdu_busy).
  - Either source stalls, so a faulty MDU causes a conservative stall rather than a hazard.
  - Stalling only blocks the D-stage instruction. The E-stage instruction always proceeds.
- Consistency check: busy_mismatch <= busy_mismatch or (model_busy != mdu_busy). Evaluated every non-reset cycle; cleared only by reset.
- Statistics counters:
  - stat_stalls increments on stall_d; stat_issues increments on mdu_start.
  - Both saturate at all-ones and never wrap.
- Back-to-back issue cannot happen in normal flow, because stall_d prevents it. If E nonetheless presents a start while cnt != 0, the new start wins: cnt is reloaded and the MDU is restarted.
- Reset mid-operation: cnt and state clear in the same cycle and mdu_start is suppressed. The MDU resets concurrently, so no mismatch is flagged.

Decomposition:
- Shared package (mdu_pkg):
  - Op-code constants: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_SWAP, OP_NONE.
  - HI/LO select constants: RD_LO, RD_HI, RD_NONE.
  - Default latencies.
  - Both the MDU and this block use the package.
- One natural sub-module, sat_counter, parameterised by width; instantiated twice for the statistics counters.

Test Plan:
- mult (0001) issued at cycle 10 with a real MDU (Time 5) -> mdu_start=1 and mdu_time=5 at cycle 10; stall_d=1 for a D-stage mflo during cycles 10..15 and 0 at cycle 16; busy_mismatch stays 0.
- divu (0100) issued, then mfhi held in D -> mdu_time=10; 11 stall cycles; stat_stalls=11, stat_issues=1.
- mthi (0101) with e_valid=1 during RUN -> cnt=0 and state=IDLE next cycle; mdu_op=0101; mdu_start=0.
- Bubble (e_valid=0, e_mdu_op=0101) -> mdu_op=0000 and mdu_read_hilo=00; no HI/LO change.
- Reset asserted 3 cycles into a div -> cnt=0, stall_d=0 and counters=0 the next cycle; busy_mismatch=0.
- mdu_busy forced 0 during a mult's RUN -> busy_mismatch=1 and stays set until reset; stall_d still follows model_busy.
